load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly downstream of the single-cycle RISC-V CPU's data-memory port, between the core's execute stage and the data memory.
- Accepts one load/store request at a time from the core and checks alignment and the funct3 encoding.
- Generates word-aligned memory accesses with byte strobes, waits for a variable-latency memory acknowledge, and returns sign- or zero-extended load data.
- The core holds its PC while lsu_req_ready is low or a response is pending.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ without mem_ack before aborting with timeout error (1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
lsu_req_valid  input  1  core presents a request
lsu_req_ready  output  1  LSU can accept a request this cycle
lsu_is_store  input  1  1=store (SB/SH/SW), 0=load
lsu_funct3  input  3  RISC-V funct3 of the load/store
lsu_addr  input  32  effective byte address (rs1+imm)
lsu_wdata  input  32  store data (rs2)
lsu_resp_valid  output  1  one-cycle pulse, transaction complete
lsu_rdata  output  32  formatted load result, valid with lsu_resp_valid
lsu_err  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout; valid with lsu_resp_valid
mem_req  output  1  memory access request, held until mem_ack
mem_we  output  1  1=write
mem_addr  output  32  word address ({addr[31:2],2'b00})
mem_wstrb  output  4  byte write enables, 0000 for reads
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory completes the access this cycle
mem_rdata  input  32  read word, valid with mem_ack

Behaviour:
- Interface: clk and rst as named; one clock domain; reset is synchronous, active-high.
- Reset, on any edge with rst=1:
  - state goes to IDLE, timeout counter goes to 0.
  - lsu_resp_valid=0, lsu_rdata=0, lsu_err=00, mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0.
  - lsu_req_ready=0 while rst is high.
- Reset mid-transaction abandons the transaction: mem_req falls at that edge, no response is issued, and any later mem_ack is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - lsu_req_ready=1. Accept on lsu_req_valid at edge T and latch all request fields.
  - Illegal encodings: load funct3 3, 6 or 7; store funct3 >=3. Result is err=10.
  - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. Result is err=01.
  - Illegal takes priority over misaligned.
  - On error go to RESP with no memory access (mem_req stays 0). Otherwise go to REQ.
  - mem_ack seen in IDLE is ignored.
- REQ:
  - lsu_req_ready=0; mem_req=1; mem_we, mem_addr, mem_wstrb and mem_wdata stay stable until ack.
  - On mem_ack: capture mem_rdata, go to RESP, drop mem_req at the same edge. An ack in the first REQ cycle is legal.
  - Counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES: go to RESP with err=11, drop mem_req, rdata=0.
- RESP:
  - lsu_resp_valid=1 for exactly one cycle, lsu_req_ready=0, then return to IDLE.
  - The next request can be accepted in the cycle after RESP.
- Latency:
  - Accept at edge T; mem_req high from T.
  - Ack sampled at edge T+k (k>=1); resp_valid is high in cycle T+k.
  - Error path: resp_valid high in cycle T (after edge T), i.e. 1 cycle after accept.
- Store lanes, with b = addr[1:0]:
  - SB: wdata = {4{wdata[7:0]}}, wstrb = 1<<b.
  - SH: wdata = {2{wdata[15:0]}}, wstrb = 0011 if b=0, 1100 if b=2.
  - SW: wdata unchanged, wstrb = 1111.
- Load formatting:
  - LB/LBU: byte = rdata[8b+7:8b].
  - LH/LHU: half = rdata[16*addr[1]+15:16*addr[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- lsu_rdata is 0 for stores and for any error. It holds its last value outside RESP and is only meaningful with resp_valid.
- lsu_req_valid while not ready is ignored; the core must hold its request.

Test Plan:
- LW at 0x100, mem_rdata=0xDEADBEEF, ack 3 cycles after mem_req rises -> mem_addr=0x100, wstrb=0000, one resp pulse, rdata=0xDEADBEEF, err=00, req_ready low throughout.
- LB/LBU/LH/LHU at 0x203 and 0x202 with mem_rdata=0x80F0_7F01 -> LB@0x203=0xFFFFFF80, LBU@0x203=0x00000080, LH@0x202=0xFFFF80F0, LHU@0x202=0x000080F0.
- SB 0xAB at 0x11 and SH 0x1234 at 0x12 -> mem_addr=0x10; wdata=0xABABABAB with wstrb=0010; wdata=0x12341234 with wstrb=1100; mem_we=1.
- LW at 0x102, then SH at 0x101, then load funct3=3 at 0x0 -> no mem_req; resp next cycle with err=01, 01, 10 respectively.
- TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req high 4 cycles then low, resp_valid with err=11, rdata=0; a late mem_ack afterwards is ignored.
- rst asserted during REQ (cycle 2 of wait) -> mem_req=0 and state IDLE after that edge, no resp_valid; a new LW after rst deasserts completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the core's data-memory port and a variable-latency
// data memory: decodes and checks one access at a time, drives byte lanes, formats load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_is_store,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
    localparam logic [7:0] TMO_LAST     = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic        r_is_store;
    logic [1:0]  r_addr_lo;

    logic        w_illegal;
    logic        w_misaligned;
    logic [3:0]  w_st_wstrb;
    logic [31:0] w_st_wdata;
    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    assign lsu_req_ready = (r_state == S_IDLE) && !rst;

    // Request decode on the live inputs; only consulted in IDLE at accept.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        if (lsu_is_store) begin
            w_illegal = (lsu_funct3 >= 3'd3);
        end else begin
            w_illegal = (lsu_funct3 == 3'd3) || (lsu_funct3 == 3'd6) || (lsu_funct3 == 3'd7);
        end
        if (lsu_funct3[1:0] == 2'b01) begin
            w_misaligned = lsu_addr[0];
        end else if (lsu_funct3[1:0] == 2'b10) begin
            w_misaligned = (lsu_addr[1:0] != 2'b00);
        end
    end

    always_comb begin
        w_st_wstrb = 4'b0000;
        w_st_wdata = 32'h0;
        if (lsu_is_store) begin
            case (lsu_funct3[1:0])
                2'b00: begin
                    w_st_wstrb = 4'b0001 << lsu_addr[1:0];
                    w_st_wdata = {4{lsu_wdata[7:0]}};
                end
                2'b01: begin
                    w_st_wstrb = lsu_addr[1] ? 4'b1100 : 4'b0011;
                    w_st_wdata = {2{lsu_wdata[15:0]}};
                end
                default: begin
                    w_st_wstrb = 4'b1111;
                    w_st_wdata = lsu_wdata;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_byte = w_lane[r_addr_lo];
    assign w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    // Loads are formatted straight off mem_rdata in the ack cycle.
    always_comb begin
        w_ld_data = 32'h0;
        if (!r_is_store) begin
            case (r_funct3)
                3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
                3'b100:  w_ld_data = {24'h0, w_byte};
                3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
                3'b101:  w_ld_data = {16'h0, w_half};
                3'b010:  w_ld_data = mem_rdata;
                default: w_ld_data = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= 8'd0;
            r_funct3       <= 3'd0;
            r_is_store     <= 1'b0;
            r_addr_lo      <= 2'b00;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= 32'h0;
            lsu_err        <= ERR_OK;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 32'h0;
            mem_wstrb      <= 4'b0000;
            mem_wdata      <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    lsu_resp_valid <= 1'b0;
                    if (lsu_req_valid) begin
                        r_funct3   <= lsu_funct3;
                        r_is_store <= lsu_is_store;
                        r_addr_lo  <= lsu_addr[1:0];
                        r_cnt      <= 8'd0;
                        if (w_illegal || w_misaligned) begin
                            r_state        <= S_RESP;
                            lsu_resp_valid <= 1'b1;
                            lsu_rdata      <= 32'h0;
                            lsu_err        <= w_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                        end else begin
                            r_state   <= S_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= lsu_is_store;
                            mem_addr  <= {lsu_addr[31:2], 2'b00};
                            mem_wstrb <= w_st_wstrb;
                            mem_wdata <= w_st_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_state        <= S_RESP;
                        mem_req        <= 1'b0;
                        lsu_resp_valid <= 1'b1;
                        lsu_rdata      <= w_ld_data;
                        lsu_err        <= ERR_OK;
                    end else if (r_cnt == TMO_LAST) begin
                        r_state        <= S_RESP;
                        mem_req        <= 1'b0;
                        lsu_resp_valid <= 1'b1;
                        lsu_rdata      <= 32'h0;
                        lsu_err        <= ERR_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    lsu_resp_valid <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: begin
                    lsu_resp_valid <= 1'b0;
                    mem_req        <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected memory
// accesses and responses; monitors pop and compare when the DUT presents them.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_is_store;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_is_store(lsu_is_store), .lsu_funct3(lsu_funct3),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          cyc;
    } resp_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        bit          chk_wdata;
    } memx_t;

    resp_t resp_q[$];
    memx_t mem_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    bit    mem_req_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Memory-side monitor: each rising mem_req is checked against the next expected access.
    always @(negedge clk) begin
        if (mem_req === 1'b1 && !mem_req_prev) begin
            if (mem_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_mem_req: got addr 0x%08h, expected no access", mem_addr);
            end else begin
                memx_t m;
                m = mem_q.pop_front();
                chk({m.name, "_mem_addr"}, mem_addr, m.addr);
                chk({m.name, "_mem_we"}, {31'h0, mem_we}, {31'h0, m.we});
                chk({m.name, "_mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, m.wstrb});
                if (m.chk_wdata) chk({m.name, "_mem_wdata"}, mem_wdata, m.wdata);
                $display("mem  %s addr=%08h we=%0d strb=%b wdata=%08h", m.name, mem_addr, mem_we, mem_wstrb, mem_wdata);
            end
        end
        mem_req_prev = (mem_req === 1'b1);
    end

    // Response monitor.
    always @(negedge clk) begin
        if (lsu_resp_valid === 1'b1) begin
            if (resp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_resp: got rdata 0x%08h err %0d, expected no response", lsu_rdata, lsu_err);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                chk({r.name, "_rdata"}, lsu_rdata, r.rdata);
                chk({r.name, "_err"}, {30'h0, lsu_err}, {30'h0, r.err});
                chk({r.name, "_resp_cycle"}, cyc, r.cyc);
                chk({r.name, "_ready_in_resp"}, {31'h0, lsu_req_ready}, 32'h0);
                chk({r.name, "_mem_req_in_resp"}, {31'h0, mem_req}, 32'h0);
                $display("resp %s rdata=%08h err=%0d cyc=%0d", r.name, lsu_rdata, lsu_err, cyc);
            end
        end
    end

    task automatic send(input string nm, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit exp_mem, input logic [31:0] maddr, input bit mwe,
                        input logic [3:0] mstrb, input logic [31:0] mwd, input bit chk_wd,
                        input bit exp_resp, input logic [31:0] exp_rd, input logic [1:0] exp_err,
                        input int k);
        memx_t m;
        resp_t r;
        if (exp_mem) begin
            m.name = nm; m.addr = maddr; m.we = mwe; m.wstrb = mstrb;
            m.wdata = mwd; m.chk_wdata = chk_wd;
            mem_q.push_back(m);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (lsu_req_ready) break;
        end
        chk({nm, "_ready_before_accept"}, {31'h0, lsu_req_ready}, 32'h1);
        lsu_req_valid = 1'b1;
        lsu_is_store  = st;
        lsu_funct3    = f3;
        lsu_addr      = a;
        lsu_wdata     = wd;
        @(posedge clk);
        #1;
        lsu_req_valid = 1'b0;
        if (exp_resp) begin
            r.name = nm; r.rdata = exp_rd; r.err = exp_err; r.cyc = cyc + k;
            resp_q.push_back(r);
        end
    endtask

    task automatic ack_after(input int k, input logic [31:0] rd);
        repeat (k) @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h3C3C_3C3C;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 60; i++) begin
            if (resp_q.size() == 0) break;
            @(negedge clk);
        end
        chk({nm, "_resp_pending"}, resp_q.size(), 0);
        chk({nm, "_mem_pending"}, mem_q.size(), 0);
        resp_q.delete();
        mem_q.delete();
    endtask

    task automatic load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] mrd, input int k, input logic [31:0] exp_rd);
        send(nm, 1'b0, f3, a, 32'hFFFF_FFFF, 1'b1, {a[31:2], 2'b00}, 1'b0, 4'b0000, 32'h0, 1'b0,
             1'b1, exp_rd, 2'b00, k);
        ack_after(k, mrd);
        drain(nm);
    endtask

    task automatic store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int k, input logic [31:0] mwd,
                         input logic [3:0] mstrb);
        send(nm, 1'b1, f3, a, wd, 1'b1, {a[31:2], 2'b00}, 1'b1, mstrb, mwd, 1'b1,
             1'b1, 32'h0, 2'b00, k);
        ack_after(k, 32'h5A5A_5A5A);
        drain(nm);
    endtask

    task automatic bad(input string nm, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [1:0] err);
        send(nm, st, f3, a, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0,
             1'b1, 32'h0, err, 0);
        drain(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        lsu_req_valid = 1'b0; lsu_is_store = 1'b0; lsu_funct3 = 3'd0;
        lsu_addr = 32'h0; lsu_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h3C3C_3C3C;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, lsu_req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, lsu_resp_valid}, 32'h0);
        chk("rst_rdata", lsu_rdata, 32'h0);
        chk("rst_err", {30'h0, lsu_err}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        #1;
        chk("idle_ready", {31'h0, lsu_req_ready}, 32'h1);

        // Loads: word, then sub-word lanes with sign/zero extension.
        load("lw_100",  3'b010, 32'h100, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);
        load("lb_203",  3'b000, 32'h203, 32'h80F0_7F01, 1, 32'hFFFF_FF80);
        load("lbu_203", 3'b100, 32'h203, 32'h80F0_7F01, 2, 32'h0000_0080);
        load("lh_202",  3'b001, 32'h202, 32'h80F0_7F01, 1, 32'hFFFF_80F0);
        load("lhu_202", 3'b101, 32'h202, 32'h80F0_7F01, 2, 32'h0000_80F0);
        load("lb_201",  3'b000, 32'h201, 32'h80F0_7F01, 1, 32'h0000_007F);
        load("lh_200",  3'b001, 32'h200, 32'h80F0_7F01, 1, 32'h0000_7F01);
        load("lbu_200", 3'b100, 32'h200, 32'h80F0_7F01, 2, 32'h0000_0001);

        // Stores: lane replication and byte strobes.
        store("sb_11", 3'b000, 32'h11, 32'h1234_56AB, 2, 32'hABAB_ABAB, 4'b0010);
        store("sh_12", 3'b001, 32'h12, 32'hFFFF_1234, 1, 32'h1234_1234, 4'b1100);
        store("sh_10", 3'b001, 32'h10, 32'h0000_BEEF, 3, 32'hBEEF_BEEF, 4'b0011);
        store("sb_13", 3'b000, 32'h13, 32'h0000_00CD, 1, 32'hCDCD_CDCD, 4'b1000);
        store("sw_20", 3'b010, 32'h20, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 4'b1111);

        // Error paths: no memory access, response one cycle after accept.
        bad("lw_102",   1'b0, 3'b010, 32'h102, 2'b01);
        bad("sh_101",   1'b1, 3'b001, 32'h101, 2'b01);
        bad("ld_f3_3",  1'b0, 3'b011, 32'h0,   2'b10);
        bad("st_f3_3",  1'b1, 3'b011, 32'h3,   2'b10);
        bad("ld_f3_6",  1'b0, 3'b110, 32'h0,   2'b10);
        bad("st_f3_4",  1'b1, 3'b100, 32'h1,   2'b10);
        bad("lh_201",   1'b0, 3'b001, 32'h201, 2'b01);

        // Timeout: no ack ever, then a stray ack must be ignored.
        mem_rdata = 32'h7777_7777;
        send("lw_tmo", 1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 32'h400, 1'b0, 4'b0000, 32'h0, 1'b0,
             1'b1, 32'h0, 2'b11, TMO);
        drain("lw_tmo");
        @(negedge clk);
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_ack_ready", {31'h0, lsu_req_ready}, 32'h1);

        // Reset in the second wait cycle abandons the access.
        send("lw_rst", 1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 32'h300, 1'b0, 4'b0000, 32'h0, 1'b0,
             1'b0, 32'h0, 2'b00, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mid_ready", {31'h0, lsu_req_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h9999_9999;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle_ready", {31'h0, lsu_req_ready}, 32'h1);
        load("lw_after_rst", 3'b010, 32'h104, 32'h1234_5678, 2, 32'h1234_5678);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
